alarm_ctrl_fsm: RTL and testbench
=================================

Name: alarm_ctrl_fsm

Overview:
Control FSM for the alarm clock display and entry datapath. It sequences key entry, drives the display select lines (show_alarm, show_new_time) consumed by the LCD decode/mux stage, and issues load strobes for the alarm and current-time registers. It also issues shift strobes to the key shift register. A one_second-driven inactivity timeout aborts abandoned key entry.

Parameters:
NOKEY, 4'd10, key code meaning "no key pressed"; any other value is a valid key press.
TIMEOUT_S, 10, number of one_second pulses of inactivity before key entry is aborted (range 2..15).

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset; state and counter clear immediately when low.
one_second  input  1  single-cycle pulse, once per second.
key  input  4  current keypad code; NOKEY when idle.
alarm_button  input  1  level; alarm view / store-alarm request.
time_button  input  1  level; store-time request.
show_alarm  output  1  display-mux select: show alarm register.
show_new_time  output  1  display-mux select: show key-entry register.
load_new_alarm  output  1  one-cycle strobe: capture entered value into alarm register.
load_new_time  output  1  one-cycle strobe: capture entered value into current-time counter.
shift  output  1  one-cycle strobe: shift key into entry register.
reset_count  output  1  one-cycle strobe: timeout counter cleared (exported for debug/verification).

Behaviour:
- The already-decided interface: one clock; reset is asynchronous and active-low. Ports are named clock and reset. reset low forces state=SHOW_TIME and tcount=0 immediately. All outputs are 0 while reset is low. Reset mid-entry discards the entry and issues no load strobe.
- States (3-bit encoding in the package): SHOW_TIME, SHOW_ALARM, KEY_STORED, KEY_WAITED, KEY_ENTRY.
- timeout = (tcount == TIMEOUT_S-1) && one_second.
- SHOW_TIME:
  - alarm_button=1 -> SHOW_ALARM (alarm_button has priority over key).
  - else key!=NOKEY -> KEY_STORED.
  - else stay.
- SHOW_ALARM:
  - Moore show_alarm=1.
  - alarm_button=0 -> SHOW_TIME; key input is ignored.
- KEY_STORED:
  - Moore shift=1, reset_count=1, show_new_time=1.
  - Unconditionally -> KEY_WAITED; lasts exactly one cycle.
- KEY_WAITED (waiting for key release):
  - show_new_time=1.
  - key==NOKEY -> KEY_ENTRY.
  - else timeout -> SHOW_TIME.
  - else stay. A held key never produces a second shift.
- KEY_ENTRY:
  - show_new_time=1.
  - alarm_button=1 -> SHOW_TIME, Mealy load_new_alarm=1 in that cycle.
  - else time_button=1 -> SHOW_TIME, Mealy load_new_time=1.
  - else key!=NOKEY -> KEY_STORED.
  - else timeout -> SHOW_TIME with no strobe.
  - Priority: alarm_button > time_button > key > timeout. Both buttons together give load_new_alarm only.
- Timeout counter tcount (4-bit):
  - Cleared when reset_count=1 and in SHOW_TIME/SHOW_ALARM.
  - In KEY_WAITED/KEY_ENTRY, increments on each one_second pulse and saturates at TIMEOUT_S-1.
  - The timeout transition takes effect on the clock edge where the TIMEOUT_S-th pulse is sampled; tcount returns to 0 in the next state.
- Strobes are never asserted simultaneously. show_alarm and show_new_time are never both 1.
- All outputs are decoded from the registered state (plus the Mealy loads). Zero-cycle latency from state to outputs.

Decomposition:
- Package alarm_clock_pkg: state encoding constants, NOKEY, and the default TIMEOUT_S.
- Sub-module timeout_counter (clock, reset, clear, enable, one_second -> timeout) is natural. The FSM is one next-state block, one state register and one output decoder.

Test Plan:
1. Assert reset low mid-KEY_ENTRY with key=4'd3 -> state SHOW_TIME immediately, all outputs 0. No load strobe after reset is released.
2. From SHOW_TIME, key=4'd5 for 3 cycles, then NOKEY, then alarm_button=1 for 1 cycle -> shift high exactly 1 cycle, show_new_time high through entry, load_new_alarm high 1 cycle, then SHOW_TIME.
3. Key entry of 4'd7, release, time_button=1 and alarm_button=1 in the same cycle -> load_new_alarm=1, load_new_time=0.
4. Key entry, release, apply 9 one_second pulses -> still KEY_ENTRY. 10th pulse -> SHOW_TIME, no strobes, show_new_time drops.
5. alarm_button held 5 cycles in SHOW_TIME with key=4'd2 simultaneously -> show_alarm=1 for the hold duration, shift never asserted. Release -> show_alarm=0 the next cycle.
6. Key 4'd4 held across 10 one_second pulses in KEY_WAITED -> return to SHOW_TIME with only one shift strobe. A second key entry restarts the count from 0 (reset_count pulse observed).

Source files
------------

// File: rtl/alarm_ctrl_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alarm_clock_pkg
// Purpose  : Shared constants and state encoding for the alarm clock
//            control FSM and its timeout counter.
// Revision : 1.0 - initial release
// ============================================================================
package alarm_clock_pkg;

  // Keypad code meaning "no key pressed"; every other code is a key press.
  localparam logic [3:0] NOKEY = 4'd10;

  // Default number of one_second pulses of inactivity before entry aborts.
  localparam int TIMEOUT_S_DEFAULT = 10;

  // Control FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    SHOW_TIME  = 3'd0,
    SHOW_ALARM = 3'd1,
    KEY_STORED = 3'd2,
    KEY_WAITED = 3'd3,
    KEY_ENTRY  = 3'd4
  } state_t;

endpackage : alarm_clock_pkg
`default_nettype wire

// File: rtl/alarm_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : alarm_ctrl_fsm_if
// Purpose  : Keypad/button inputs and display/strobe outputs of the alarm
//            clock control FSM. The FSM is the slave; the surrounding
//            datapath (or a bench) is the master.
// Revision : 1.0 - initial release
// ============================================================================
interface alarm_ctrl_fsm_if;

  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       show_alarm;
  logic       show_new_time;
  logic       load_new_alarm;
  logic       load_new_time;
  logic       shift;
  logic       reset_count;

  modport master (
    output one_second, key, alarm_button, time_button,
    input  show_alarm, show_new_time, load_new_alarm, load_new_time,
           shift, reset_count
  );

  modport slave (
    input  one_second, key, alarm_button, time_button,
    output show_alarm, show_new_time, load_new_alarm, load_new_time,
           shift, reset_count
  );

endinterface : alarm_ctrl_fsm_if
`default_nettype wire

// File: rtl/alarm_ctrl_fsm_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : timeout_counter
// Purpose  : Counts one_second pulses while key entry is active and flags
//            the pulse that completes TIMEOUT_S seconds of inactivity.
//            The count saturates at TIMEOUT_S-1.
// Revision : 1.0 - initial release
// ============================================================================
module timeout_counter #(
  parameter int TIMEOUT_S = 10
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic clear,
  input  wire logic enable,
  input  wire logic one_second,
  output logic      timeout
);

  localparam logic [3:0] C_LAST = 4'(TIMEOUT_S - 1);

  logic [3:0] r_tcount;
  logic       w_at_last;

  assign w_at_last = (r_tcount == C_LAST);
  assign timeout   = enable && w_at_last && one_second;

  // Inactivity count: cleared on request, counts seconds while enabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tcount <= 4'd0;
    end else if (clear) begin
      r_tcount <= 4'd0;
    end else if (enable && one_second && !w_at_last) begin
      r_tcount <= r_tcount + 4'd1;
    end
  end

endmodule : timeout_counter
`default_nettype wire

// File: rtl/alarm_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : alarm_ctrl_fsm
// Purpose  : Alarm clock control FSM. Sequences key entry, selects the
//            display source and issues load/shift strobes. Abandoned key
//            entry is aborted after TIMEOUT_S seconds of inactivity.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_ctrl_fsm
  import alarm_clock_pkg::*;
#(
  parameter int TIMEOUT_S = TIMEOUT_S_DEFAULT
) (
  input  wire logic       clock,
  input  wire logic       reset,
  alarm_ctrl_fsm_if.slave bus
);

  state_t r_state;
  state_t w_state_next;
  logic   w_timeout;
  logic   w_count_clear;
  logic   w_count_enable;
  logic   w_key_pressed;
  logic   w_show_alarm;
  logic   w_show_new_time;
  logic   w_load_new_alarm;
  logic   w_load_new_time;
  logic   w_shift;

  assign w_key_pressed = (bus.key != NOKEY);

  // Counter runs only while an entry is pending; the idle views and a
  // fresh key press restart it.
  assign w_count_enable = (r_state == KEY_WAITED) || (r_state == KEY_ENTRY);
  assign w_count_clear  = w_shift || (r_state == SHOW_TIME) ||
                          (r_state == SHOW_ALARM);

  timeout_counter #(
    .TIMEOUT_S (TIMEOUT_S)
  ) u_timeout_counter (
    .clock      (clock),
    .reset      (reset),
    .clear      (w_count_clear),
    .enable     (w_count_enable),
    .one_second (bus.one_second),
    .timeout    (w_timeout)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= SHOW_TIME;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; button priority is alarm > time > key > timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SHOW_TIME: begin
        if (bus.alarm_button)   w_state_next = SHOW_ALARM;
        else if (w_key_pressed) w_state_next = KEY_STORED;
      end
      SHOW_ALARM: begin
        if (!bus.alarm_button) w_state_next = SHOW_TIME;
      end
      KEY_STORED: begin
        w_state_next = KEY_WAITED;
      end
      KEY_WAITED: begin
        if (!w_key_pressed) w_state_next = KEY_ENTRY;
        else if (w_timeout) w_state_next = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (bus.alarm_button || bus.time_button) w_state_next = SHOW_TIME;
        else if (w_key_pressed)                  w_state_next = KEY_STORED;
        else if (w_timeout)                      w_state_next = SHOW_TIME;
      end
      default: begin
        w_state_next = SHOW_TIME;
      end
    endcase
  end

  // Output decode: Moore display selects and shift, Mealy load strobes.
  always_comb begin
    w_show_alarm     = 1'b0;
    w_show_new_time  = 1'b0;
    w_load_new_alarm = 1'b0;
    w_load_new_time  = 1'b0;
    w_shift          = 1'b0;
    case (r_state)
      SHOW_ALARM: begin
        w_show_alarm = 1'b1;
      end
      KEY_STORED: begin
        w_show_new_time = 1'b1;
        w_shift         = 1'b1;
      end
      KEY_WAITED: begin
        w_show_new_time = 1'b1;
      end
      KEY_ENTRY: begin
        w_show_new_time  = 1'b1;
        w_load_new_alarm = bus.alarm_button;
        w_load_new_time  = !bus.alarm_button && bus.time_button;
      end
      default: begin
        w_show_alarm = 1'b0;
      end
    endcase
  end

  assign bus.show_alarm     = w_show_alarm;
  assign bus.show_new_time  = w_show_new_time;
  assign bus.load_new_alarm = w_load_new_alarm;
  assign bus.load_new_time  = w_load_new_time;
  assign bus.shift          = w_shift;
  assign bus.reset_count    = w_shift;

endmodule : alarm_ctrl_fsm
`default_nettype wire

// File: tb/tb_alarm_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_ctrl_fsm
// Purpose  : Self-checking bench for alarm_ctrl_fsm: a behavioural model of
//            the entry sequence is compared against the DUT every cycle, and
//            directed scenarios pin strobe counts with literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_ctrl_fsm;

  localparam int         T_S = 10;
  localparam logic [3:0] NK  = 4'd10;

  logic clock;
  logic reset;

  alarm_ctrl_fsm_if bus ();

  alarm_ctrl_fsm #(
    .TIMEOUT_S (T_S)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock, 10 time units.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, time=%0t required < 200000", $time);
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  // The user is either viewing time, viewing the alarm, or entering digits.
  // During entry: a fresh press gives one shift cycle, then the key must be
  // released, then the user may press more keys or a button; m_idle counts
  // idle seconds since the last press.
  bit m_alarm_view, m_entering, m_just_pressed, m_await_release;
  int m_idle;

  always @(posedge clock or negedge reset) begin
    bit expired;
    if (!reset) begin
      m_alarm_view    = 0;
      m_entering      = 0;
      m_just_pressed  = 0;
      m_await_release = 0;
      m_idle          = 0;
    end else if (m_alarm_view) begin
      m_alarm_view = bus.alarm_button;
    end else if (!m_entering) begin
      if (bus.alarm_button) m_alarm_view = 1;
      else if (bus.key != NK) begin
        m_entering     = 1;
        m_just_pressed = 1;
      end
    end else if (m_just_pressed) begin
      m_just_pressed  = 0;
      m_await_release = 1;
      m_idle          = 0;
    end else begin
      expired = bus.one_second && (m_idle == T_S - 1);
      if (bus.one_second && m_idle < T_S - 1) m_idle = m_idle + 1;
      if (m_await_release) begin
        if (bus.key == NK) m_await_release = 0;
        else if (expired) begin
          m_entering      = 0;
          m_await_release = 0;
        end
      end else if (bus.alarm_button || bus.time_button) m_entering = 0;
      else if (bus.key != NK) m_just_pressed = 1;
      else if (expired) m_entering = 0;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;
  int n_shift = 0, n_rc = 0, n_lna = 0, n_lnt = 0, n_sa = 0, n_snt = 0;

  function automatic logic [5:0] dut_vec();
    return {bus.show_alarm, bus.show_new_time, bus.load_new_alarm,
            bus.load_new_time, bus.shift, bus.reset_count};
  endfunction

  function automatic logic [5:0] model_vec();
    bit in_entry;
    in_entry = m_entering && !m_just_pressed && !m_await_release;
    if (!reset) return 6'b0;
    return {m_alarm_view, m_entering,
            in_entry && bus.alarm_button,
            in_entry && !bus.alarm_button && bus.time_button,
            m_just_pressed, m_just_pressed};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare at the falling edge, tally strobes, then return
  // just after the next rising edge where the caller drives new inputs.
  task automatic cyc();
    logic [5:0] a, e;
    @(negedge clock);
    a = dut_vec();
    e = model_vec();
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL cycle_outputs {sa,snt,lna,lnt,sh,rc}: got %b expected %b (t=%0t)",
               a, e, $time);
    end
    n_shift += int'(bus.shift);
    n_rc    += int'(bus.reset_count);
    n_lna   += int'(bus.load_new_alarm);
    n_lnt   += int'(bus.load_new_time);
    n_sa    += int'(bus.show_alarm);
    n_snt   += int'(bus.show_new_time);
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Press key k for one cycle and release; ends with the FSM in entry.
  task automatic enter(input logic [3:0] k);
    bus.key = k;
    cyc();
    bus.key = NK;
    cyc();
    cyc();
  endtask

  task automatic pulse();
    bus.one_second = 1'b1;
    cyc();
    bus.one_second = 1'b0;
    cyc();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int s_shift, s_rc, s_lna, s_lnt, s_sa, s_snt;

    reset            = 1'b0;
    bus.one_second   = 1'b0;
    bus.key          = NK;
    bus.alarm_button = 1'b0;
    bus.time_button  = 1'b0;
    idle_cycles(2);
    chk("reset_outputs_zero", int'(dut_vec()), 0);
    reset = 1'b1;
    idle_cycles(2);

    // Scenario 1: reset mid-entry with a key pressed.
    enter(4'd8);
    chk("s1_in_entry", int'(bus.show_new_time), 1);
    bus.key = 4'd3;
    #1 reset = 1'b0;
    #1 chk("s1_async_reset_outputs", int'(dut_vec()), 0);
    cyc();
    bus.key = NK;
    #2 reset = 1'b1;
    s_lna = n_lna; s_lnt = n_lnt; s_shift = n_shift;
    idle_cycles(4);
    chk("s1_no_load_after_reset", (n_lna - s_lna) + (n_lnt - s_lnt), 0);
    chk("s1_no_shift_after_reset", n_shift - s_shift, 0);

    // Scenario 2: key held 3 cycles, release, store as alarm.
    s_shift = n_shift; s_lna = n_lna; s_snt = n_snt;
    bus.key = 4'd5;
    idle_cycles(3);
    bus.key = NK;
    cyc();
    bus.alarm_button = 1'b1;
    cyc();
    bus.alarm_button = 1'b0;
    cyc();
    chk("s2_shift_count", n_shift - s_shift, 1);
    chk("s2_load_alarm_count", n_lna - s_lna, 1);
    chk("s2_show_new_time_cycles", n_snt - s_snt, 4);
    chk("s2_back_to_time", int'(bus.show_new_time), 0);

    // Scenario 3: both buttons together load the alarm only.
    s_lna = n_lna; s_lnt = n_lnt;
    enter(4'd7);
    bus.alarm_button = 1'b1;
    bus.time_button  = 1'b1;
    cyc();
    bus.alarm_button = 1'b0;
    bus.time_button  = 1'b0;
    cyc();
    chk("s3_load_alarm_count", n_lna - s_lna, 1);
    chk("s3_load_time_count", n_lnt - s_lnt, 0);

    // Scenario 4: inactivity timeout in entry.
    s_lna = n_lna; s_lnt = n_lnt;
    enter(4'd6);
    for (int i = 0; i < 9; i++) pulse();
    chk("s4_still_entry_after_9", int'(bus.show_new_time), 1);
    pulse();
    chk("s4_timeout_after_10", int'(bus.show_new_time), 0);
    chk("s4_no_load_on_timeout", (n_lna - s_lna) + (n_lnt - s_lnt), 0);

    // Scenario 5: alarm view has priority over a key.
    s_shift = n_shift; s_sa = n_sa;
    bus.alarm_button = 1'b1;
    bus.key          = 4'd2;
    idle_cycles(5);
    bus.alarm_button = 1'b0;
    bus.key          = NK;
    cyc();
    chk("s5_show_alarm_cycles", n_sa - s_sa, 5);
    chk("s5_no_shift", n_shift - s_shift, 0);
    chk("s5_show_alarm_dropped", int'(bus.show_alarm), 0);
    cyc();

    // Scenario 6: held key times out with a single shift, then a new entry
    // restarts the count.
    s_shift = n_shift;
    bus.key = 4'd4;
    idle_cycles(2);
    for (int i = 0; i < 10; i++) begin
      bus.one_second = 1'b1;
      cyc();
      bus.one_second = 1'b0;
      if (i == 9) bus.key = NK;
      cyc();
    end
    chk("s6_held_key_timeout", int'(bus.show_new_time), 0);
    chk("s6_single_shift", n_shift - s_shift, 1);
    s_rc = n_rc; s_lnt = n_lnt;
    enter(4'd1);
    chk("s6_reset_count_pulse", n_rc - s_rc, 1);
    for (int i = 0; i < 9; i++) pulse();
    chk("s6_count_restarted", int'(bus.show_new_time), 1);
    bus.time_button = 1'b1;
    cyc();
    bus.time_button = 1'b0;
    cyc();
    chk("s6_load_time_count", n_lnt - s_lnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_alarm_ctrl_fsm
`default_nettype wire
